centroid_update_ctrl: RTL and testbench
=======================================

Name: centroid_update_ctrl

Overview:
Sequencer for the centroid-update step of the k-means engine. After an accumulation pass it walks all centroid slots in order. For each slot it:
- reads the per-centroid coordinate-sum vector and the point count,
- presents them to the shared 7-lane divider datapath,
- saturates the 7 quotients to coordinate width,
- writes the new centroid back to centroid memory.
Slots with a zero count are skipped, so the old centroid is kept. The block reports completion, empty clusters and saturation events to the top-level FSM.

Parameters:
centroid_num, 8, number of centroid slots; the slot index is clog2(centroid_num) bits wide
accum_cord_width, 22, width of one accumulated coordinate and of one quotient lane
accum_width, 7*22, packed 7-coordinate accumulator vector
cordinate_width, 13, width of one stored centroid coordinate (signed)
dataWidth, 91, centroid memory word width (7*cordinate_width)
count_width, 10, point-count width
div_latency, 1, cycles the divider inputs are held before the quotient is sampled (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin update pass; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until the DONE cycle, inclusive
done  out  1  single-cycle pulse at the end of the pass
acc_rd_en  out  1  accumulator/counter memory read strobe
acc_rd_addr  out  clog2(centroid_num)  slot being read
acc_rd_data  in  accum_width  accumulator vector; valid 1 cycle after acc_rd_en
cnt_rd_data  in  count_width  point count; valid 1 cycle after acc_rd_en
div_accum  out  accum_width  divider dividend vector (registered)
div_count  out  count_width  divider divisor (registered)
div_quot  in  7*accum_cord_width  packed quotients, lane 1 in LSBs
div_by_zero  in  1  divider divide-by-zero flag
cent_wr_en  out  1  centroid memory write strobe
cent_wr_addr  out  clog2(centroid_num)  centroid slot written
cent_wr_data  out  dataWidth  packed saturated coordinates, lane 1 in LSBs
empty_mask  out  centroid_num  bit i = slot i had count 0 in the last pass
sat_flag  out  1  sticky: some lane saturated during the last pass

Behaviour:
Reset and output rules:
- Reset is asynchronous, active-low, and takes effect immediately, including mid-pass.
- On reset: state=IDLE; all outputs and internal registers are 0; no memory write is issued.
- Registered outputs: busy, done, acc_rd_en, acc_rd_addr, div_accum, div_count, cent_wr_en, cent_wr_addr, cent_wr_data, empty_mask, sat_flag.

FSM states and transitions:
- IDLE: if start=1, clear empty_mask, sat_flag and idx, then go to RD. A start pulse in any other state is ignored.
- RD (1 cycle): acc_rd_en=1, acc_rd_addr=idx. Go to CAP.
- CAP (1 cycle):
  - Register acc_rd_data into div_accum and cnt_rd_data into div_count.
  - Set zero_flag = (cnt_rd_data==0).
  - Load wait counter = div_latency-1.
  - Go to DIV.
- DIV (div_latency cycles):
  - div_accum and div_count are held stable.
  - On the last cycle, sample div_quot and saturate each lane into the result register.
  - zero_flag |= div_by_zero.
  - Go to WR.
- WR (1 cycle):
  - cent_wr_addr=idx.
  - cent_wr_en = !zero_flag. cent_wr_data is driven even when the write is suppressed.
  - If zero_flag, set empty_mask[idx]=1.
  - If idx==centroid_num-1, go to DONE; otherwise idx++ and go to RD.
- DONE (1 cycle): done=1, then go to IDLE.

Timing:
- Per slot: 3+div_latency cycles.
- done is asserted centroid_num*(3+div_latency)+1 cycles after the start-accept edge. Defaults: 33.

Arithmetic:
- Quotient lanes are signed, two's complement, truncated toward zero by the divider.
- Saturation per lane:
  - q > 2^(cordinate_width-1)-1 maps to 4095.
  - q < -2^(cordinate_width-1) maps to -4096.
  - Otherwise the low cordinate_width bits are taken.
- Any clamp sets sat_flag, and the flag stays set until the next accepted start.

Other rules:
- empty_mask and sat_flag hold their values after DONE until the next accepted start.
- acc_rd_en and cent_wr_en are never high in the same cycle.
- At most one write per slot per pass.

Test Plan:
1. All 8 counts=4, every lane accumulator=+400 -> 8 writes, each lane=100 (0x064); addr 0..7 in order; done at cycle 33; empty_mask=0x00; sat_flag=0.
2. Slot 3 count=0, others count=2 with lane value -10 -> no write to addr 3; other slots lane=-5 (0x1FFB); empty_mask=0x08; done still at cycle 33.
3. Slot 5 lane 7 accumulator=+2,000,000, count=1 -> lane 7 written 4095; sat_flag=1. Slot 6 lane 1=-2,000,000, count=1 -> -4096 (0x1000).
4. start pulsed again at cycle 10 of a pass -> ignored: no restart, single done at cycle 33. rst_n low at cycle 15 -> busy, cent_wr_en and all outputs 0 immediately; after release with no start, no memory activity.
5. div_latency=3, all counts=1 -> 6 cycles per slot; done at cycle 49; div_accum and div_count stable across all DIV cycles.
6. div_by_zero forced 1 for slot 0 with count=7 -> no write to slot 0; empty_mask[0]=1.

Source files
------------

// File: rtl/centroid_update_ctrl.sv
// Centroid-update sequencer: walks every centroid slot, feeds sum/count to the shared divider,
// saturates the quotients and writes the new centroid back. Zero-count slots are skipped.
module centroid_update_ctrl #(
    parameter int unsigned centroid_num     = 8,
    parameter int unsigned accum_cord_width = 22,
    parameter int unsigned accum_width      = 7 * 22,
    parameter int unsigned cordinate_width  = 13,
    parameter int unsigned dataWidth        = 91,
    parameter int unsigned count_width      = 10,
    parameter int unsigned div_latency      = 1,
    localparam int unsigned idx_width = (centroid_num > 1) ? $clog2(centroid_num) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          acc_rd_en,
    output logic [idx_width-1:0]          acc_rd_addr,
    input  logic [accum_width-1:0]        acc_rd_data,
    input  logic [count_width-1:0]        cnt_rd_data,
    output logic [accum_width-1:0]        div_accum,
    output logic [count_width-1:0]        div_count,
    input  logic [7*accum_cord_width-1:0] div_quot,
    input  logic                          div_by_zero,
    output logic                          cent_wr_en,
    output logic [idx_width-1:0]          cent_wr_addr,
    output logic [dataWidth-1:0]          cent_wr_data,
    output logic [centroid_num-1:0]       empty_mask,
    output logic                          sat_flag
);

    localparam int unsigned lanes      = 7;
    localparam int unsigned wait_width = (div_latency > 1) ? $clog2(div_latency) : 1;
    localparam logic signed [accum_cord_width-1:0] sat_max =
        accum_cord_width'(2 ** (cordinate_width - 1) - 1);
    localparam logic signed [accum_cord_width-1:0] sat_min =
        accum_cord_width'(-(2 ** (cordinate_width - 1)));

    typedef enum logic [2:0] {StIdle, StRd, StCap, StDiv, StWr, StDone} state_e;

    state_e                       state_q, state_d;
    logic [idx_width-1:0]         idx_q, idx_d;
    logic [wait_width-1:0]        wait_q, wait_d;
    logic                         zero_q, zero_d;
    logic                         busy_q, busy_d, done_q, done_d;
    logic                         rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [idx_width-1:0]         rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [accum_width-1:0]       div_accum_q, div_accum_d;
    logic [count_width-1:0]       div_count_q, div_count_d;
    logic [dataWidth-1:0]         wr_data_q, wr_data_d;
    logic [centroid_num-1:0]      empty_q, empty_d;
    logic                         sat_q, sat_d;

    logic [dataWidth-1:0]         sat_data;
    logic                         sat_any;
    logic signed [accum_cord_width-1:0] lane_q;

    // Per-lane clamp of the signed quotient to the stored coordinate range.
    always_comb begin
        sat_data = '0;
        sat_any  = 1'b0;
        lane_q   = '0;
        for (int j = 0; j < lanes; j++) begin
            lane_q = div_quot[j*accum_cord_width +: accum_cord_width];
            if (lane_q > sat_max) begin
                sat_data[j*cordinate_width +: cordinate_width] = sat_max[cordinate_width-1:0];
                sat_any = 1'b1;
            end else if (lane_q < sat_min) begin
                sat_data[j*cordinate_width +: cordinate_width] = sat_min[cordinate_width-1:0];
                sat_any = 1'b1;
            end else begin
                sat_data[j*cordinate_width +: cordinate_width] = lane_q[cordinate_width-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        zero_d      = zero_q;
        div_accum_d = div_accum_q;
        div_count_d = div_count_q;
        wr_data_d   = wr_data_q;
        empty_d     = empty_q;
        sat_d       = sat_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    empty_d = '0;
                    sat_d   = 1'b0;
                    idx_d   = '0;
                    state_d = StRd;
                end
            end
            StRd: state_d = StCap;
            StCap: begin
                div_accum_d = acc_rd_data;
                div_count_d = cnt_rd_data;
                zero_d      = (cnt_rd_data == '0);
                wait_d      = wait_width'(div_latency - 1);
                state_d     = StDiv;
            end
            StDiv: begin
                if (wait_q == '0) begin
                    wr_data_d = sat_data;
                    sat_d     = sat_q | sat_any;
                    zero_d    = zero_q | div_by_zero;
                    state_d   = StWr;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            StWr: begin
                if (zero_q) begin
                    empty_d[idx_q] = 1'b1;
                end
                if (idx_q == idx_width'(centroid_num - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StRd;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
        rd_en_d   = (state_d == StRd);
        rd_addr_d = idx_d;
        wr_en_d   = (state_d == StWr) && !zero_d;
        wr_addr_d = idx_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            wait_q      <= '0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            div_accum_q <= '0;
            div_count_q <= '0;
            wr_data_q   <= '0;
            empty_q     <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            div_accum_q <= div_accum_d;
            div_count_q <= div_count_d;
            wr_data_q   <= wr_data_d;
            empty_q     <= empty_d;
            sat_q       <= sat_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign acc_rd_en    = rd_en_q;
    assign acc_rd_addr  = rd_addr_q;
    assign div_accum    = div_accum_q;
    assign div_count    = div_count_q;
    assign cent_wr_en   = wr_en_q;
    assign cent_wr_addr = wr_addr_q;
    assign cent_wr_data = wr_data_q;
    assign empty_mask   = empty_q;
    assign sat_flag     = sat_q;

endmodule

// File: tb/tb_centroid_update_ctrl.sv
// Scoreboard bench for centroid_update_ctrl: a reference model of the update rules predicts the
// centroid writes, empty mask, saturation flag and done timing for each pass.
module tb_centroid_update_ctrl;

    localparam int N  = 8;
    localparam int W  = 22;
    localparam int AW = 7 * W;
    localparam int CW = 13;
    localparam int DW = 7 * CW;
    localparam int NW = 10;

    typedef struct packed {
        logic          inst;
        logic [2:0]    addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc       = 0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    wr_t  exp_q[$];

    logic [AW-1:0] acc_mem [N];
    logic [NW-1:0] cnt_mem [N];
    bit            force_en   = 1'b0;
    logic [2:0]    force_slot = '0;

    // Instance A: div_latency 1; instance B: div_latency 3.
    logic          start_a = 1'b0, busy_a, done_a, acc_rd_en_a, cent_wr_en_a, sat_flag_a;
    logic [2:0]    acc_rd_addr_a, cent_wr_addr_a, slot_a = '0;
    logic [AW-1:0] rd_acc_a = '0, div_accum_a, div_quot_a;
    logic [NW-1:0] rd_cnt_a = '0, div_count_a;
    logic          div_by_zero_a;
    logic [DW-1:0] cent_wr_data_a;
    logic [N-1:0]  empty_mask_a;

    logic          start_b = 1'b0, busy_b, done_b, acc_rd_en_b, cent_wr_en_b, sat_flag_b;
    logic [2:0]    acc_rd_addr_b, cent_wr_addr_b, slot_b = '0;
    logic [AW-1:0] rd_acc_b = '0, div_accum_b, div_quot_b;
    logic [NW-1:0] rd_cnt_b = '0, div_count_b;
    logic          div_by_zero_b;
    logic [DW-1:0] cent_wr_data_b;
    logic [N-1:0]  empty_mask_b;

    int act_a = 0, excl_a = 0, act_b = 0, excl_b = 0, stab_b = 0;
    logic [AW-1:0] prev_acc_b = '0;
    logic [NW-1:0] prev_cnt_b = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    centroid_update_ctrl #(.div_latency(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .acc_rd_en(acc_rd_en_a), .acc_rd_addr(acc_rd_addr_a), .acc_rd_data(rd_acc_a),
        .cnt_rd_data(rd_cnt_a), .div_accum(div_accum_a), .div_count(div_count_a),
        .div_quot(div_quot_a), .div_by_zero(div_by_zero_a), .cent_wr_en(cent_wr_en_a),
        .cent_wr_addr(cent_wr_addr_a), .cent_wr_data(cent_wr_data_a),
        .empty_mask(empty_mask_a), .sat_flag(sat_flag_a)
    );

    centroid_update_ctrl #(.div_latency(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .acc_rd_en(acc_rd_en_b), .acc_rd_addr(acc_rd_addr_b), .acc_rd_data(rd_acc_b),
        .cnt_rd_data(rd_cnt_b), .div_accum(div_accum_b), .div_count(div_count_b),
        .div_quot(div_quot_b), .div_by_zero(div_by_zero_b), .cent_wr_en(cent_wr_en_b),
        .cent_wr_addr(cent_wr_addr_b), .cent_wr_data(cent_wr_data_b),
        .empty_mask(empty_mask_b), .sat_flag(sat_flag_b)
    );

    // Divider environment: signed truncating division per lane.
    function automatic logic [AW-1:0] divide(input logic [AW-1:0] acc, input logic [NW-1:0] cnt);
        logic [AW-1:0] r;
        int a;
        r = '0;
        if (cnt != '0) begin
            for (int j = 0; j < 7; j++) begin
                a = $signed(acc[j*W +: W]);
                r[j*W +: W] = W'(a / int'(cnt));
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (acc_rd_en_a) begin
            rd_acc_a <= acc_mem[acc_rd_addr_a];
            rd_cnt_a <= cnt_mem[acc_rd_addr_a];
            slot_a   <= acc_rd_addr_a;
        end
        if (acc_rd_en_b) begin
            rd_acc_b <= acc_mem[acc_rd_addr_b];
            rd_cnt_b <= cnt_mem[acc_rd_addr_b];
            slot_b   <= acc_rd_addr_b;
        end
    end

    assign div_quot_a    = divide(div_accum_a, div_count_a);
    assign div_quot_b    = divide(div_accum_b, div_count_b);
    assign div_by_zero_a = (div_count_a == '0) || (force_en && slot_a == force_slot);
    assign div_by_zero_b = (div_count_b == '0) || (force_en && slot_b == force_slot);

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic mon_write(input logic inst, input logic [2:0] addr, input logic [DW-1:0] data);
        wr_t e;
        if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_write: got inst %0d slot %0d data %0h, want none",
                     inst, addr, data);
        end else begin
            e = exp_q.pop_front();
            check("wr_slot", {inst, addr}, {e.inst, e.addr});
            check("wr_data", data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cent_wr_en_a) mon_write(1'b0, cent_wr_addr_a, cent_wr_data_a);
            if (acc_rd_en_a || cent_wr_en_a) act_a++;
            if (acc_rd_en_a && cent_wr_en_a) excl_a++;
            if (div_accum_b == prev_acc_b && div_count_b == prev_cnt_b) stab_b++;
            else stab_b = 0;
            prev_acc_b = div_accum_b;
            prev_cnt_b = div_count_b;
            if (cent_wr_en_b) begin
                check("div_inputs_held", stab_b >= 3, 1);
                mon_write(1'b1, cent_wr_addr_b, cent_wr_data_b);
            end
            if (acc_rd_en_b || cent_wr_en_b) act_b++;
            if (acc_rd_en_b && cent_wr_en_b) excl_b++;
        end
    end

    // Reference model of one pass over the current memory contents.
    task automatic expect_pass(input logic inst, output logic [N-1:0] emp, output logic es);
        logic [DW-1:0] d;
        int q;
        wr_t e;
        emp = '0;
        es  = 1'b0;
        for (int s = 0; s < N; s++) begin
            d = '0;
            if (cnt_mem[s] == '0 || (force_en && int'(force_slot) == s)) emp[s] = 1'b1;
            if (cnt_mem[s] != '0) begin
                for (int j = 0; j < 7; j++) begin
                    q = int'($signed(acc_mem[s][j*W +: W])) / int'(cnt_mem[s]);
                    if (q > 4095) begin q = 4095; es = 1'b1; end
                    else if (q < -4096) begin q = -4096; es = 1'b1; end
                    d[j*CW +: CW] = CW'(q);
                end
            end
            if (!emp[s]) begin
                e.inst = inst;
                e.addr = 3'(s);
                e.data = d;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic set_start(input logic inst, input logic v);
        if (inst) start_b = v;
        else start_a = v;
    endtask

    task automatic run_pass(input logic inst, input int mid_cyc);
        logic [N-1:0] emp;
        logic es;
        int t0, n, ex0, lat;
        bit seen;
        lat = inst ? 3 : 1;
        expect_pass(inst, emp, es);
        ex0 = inst ? excl_b : excl_a;
        @(negedge clk);
        set_start(inst, 1'b1);
        @(posedge clk);
        #1;
        set_start(inst, 1'b0);
        t0 = cyc;
        check("busy_after_start", inst ? busy_b : busy_a, 1);
        seen = 1'b0;
        n = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            n = cyc - t0 + 1;
            if (inst ? done_b : done_a) seen = 1'b1;
            else if (mid_cyc > 0 && n == mid_cyc) set_start(inst, 1'b1);
            else set_start(inst, 1'b0);
        end
        check("done_cycle", seen ? n : -1, N * (3 + lat) + 1);
        check("empty_mask", inst ? empty_mask_b : empty_mask_a, emp);
        check("sat_flag", inst ? sat_flag_b : sat_flag_a, es);
        check("writes_left", exp_q.size(), 0);
        check("rd_wr_overlap", (inst ? excl_b : excl_a) - ex0, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        if (inst) check("held_after_done", {busy_b, done_b, empty_mask_b, sat_flag_b},
                        {2'b00, emp, es});
        else check("held_after_done", {busy_a, done_a, empty_mask_a, sat_flag_a},
                   {2'b00, emp, es});
    endtask

    task automatic reset_mid_pass();
        logic [N-1:0] emp;
        logic es;
        int t0, a0;
        expect_pass(1'b0, emp, es);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cyc - t0 + 1 >= 15) break;
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {busy_a, done_a, acc_rd_en_a, cent_wr_en_a, sat_flag_a,
                               acc_rd_addr_a, cent_wr_addr_a, empty_mask_a}, '0);
        check("rst_mid_data", div_accum_a, '0);
        check("rst_mid_wdata", {div_count_a, cent_wr_data_a}, '0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a0 = act_a;
        repeat (20) @(negedge clk);
        check("no_activity_after_reset", act_a - a0, 0);
        check("idle_after_reset", {busy_a, done_a}, 2'b00);
    endtask

    task automatic fill_const(input int cnt, input int val);
        for (int s = 0; s < N; s++) begin
            cnt_mem[s] = NW'(cnt);
            for (int j = 0; j < 7; j++) acc_mem[s][j*W +: W] = W'(val);
        end
    endtask

    task automatic fill_random(input int max_cnt, input int lim, input bit allow_zero);
        for (int s = 0; s < N; s++) begin
            cnt_mem[s] = NW'($urandom_range(max_cnt, 1));
            if (allow_zero && $urandom_range(3) == 0) cnt_mem[s] = '0;
            for (int j = 0; j < 7; j++)
                acc_mem[s][j*W +: W] = W'(int'($urandom_range(2 * lim)) - lim);
        end
    endtask

    initial begin
        fill_const(0, 0);
        repeat (3) @(negedge clk);
        check("reset_a", {busy_a, done_a, acc_rd_en_a, cent_wr_en_a, sat_flag_a,
                          empty_mask_a, cent_wr_data_a}, '0);
        check("reset_b", {busy_b, done_b, acc_rd_en_b, cent_wr_en_b, sat_flag_b,
                          empty_mask_b, cent_wr_data_b}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        fill_const(4, 400);
        run_pass(1'b0, -1);

        fill_const(2, -10);
        cnt_mem[3] = '0;
        run_pass(1'b0, -1);

        fill_random(1, 3000, 1'b0);
        acc_mem[5][6*W +: W] = W'(2000000);
        acc_mem[6][0 +: W]   = W'(-2000000);
        run_pass(1'b0, -1);

        // Exact clamp boundaries with count 1.
        fill_const(1, 0);
        for (int s = 0; s < N; s++) begin
            acc_mem[s][0*W +: W] = W'(4095);
            acc_mem[s][1*W +: W] = W'(4096);
            acc_mem[s][2*W +: W] = W'(-4096);
            acc_mem[s][3*W +: W] = W'(-4097);
            acc_mem[s][5*W +: W] = W'(-1);
            acc_mem[s][6*W +: W] = W'(2097151);
        end
        run_pass(1'b0, -1);

        fill_random(7, 20000, 1'b0);
        for (int s = 0; s < N; s++) cnt_mem[s] = NW'(7);
        force_en   = 1'b1;
        force_slot = 3'd0;
        run_pass(1'b0, -1);
        force_en = 1'b0;

        for (int r = 0; r < 3; r++) begin
            fill_random(1023, 2097151, 1'b1);
            run_pass(1'b0, -1);
        end

        fill_random(50, 100000, 1'b1);
        run_pass(1'b0, 10);

        fill_random(20, 100000, 1'b0);
        reset_mid_pass();

        fill_random(1, 5000, 1'b0);
        run_pass(1'b1, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
